// File: rtl/lab1_imul_accum_pkg.sv
// Shared types and default sizes for the multiplier product accumulator.
package lab1_imul_accum_pkg;

  localparam int unsigned W_DEF     = 32;
  localparam int unsigned NPROD_DEF = 4;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

endpackage

// File: rtl/lab1_imul_prod_accum_dpath.sv
// Accumulator datapath: acc register, adder, first-product mux and group counter.
module lab1_imul_prod_accum_dpath
  import lab1_imul_accum_pkg::*;
#(
  parameter int unsigned NPROD = NPROD_DEF,
  parameter int unsigned W     = W_DEF,
  localparam int unsigned CW   = $clog2(NPROD + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_xfer,
  input  logic [W-1:0]  in_msg,
  output logic [W-1:0]  acc,
  output logic [CW-1:0] cnt,
  output logic          last_prod
);

  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign last_prod = (cnt_q == CW'(NPROD - 1));
  assign acc       = acc_q;
  assign cnt       = cnt_q;

  // in_msg only reaches acc through the transfer branch, so idle X cannot leak in
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (in_xfer) begin
      acc_d = (cnt_q == '0) ? in_msg : acc_q + in_msg;
      cnt_d = last_prod ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lab1_imul_prod_accum.sv
// Sums every NPROD consecutive multiplier products (mod 2^W) and emits one sum per group.
module lab1_imul_prod_accum
  import lab1_imul_accum_pkg::*;
#(
  parameter int unsigned NPROD = NPROD_DEF,
  parameter int unsigned W     = W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_val,
  output logic                         in_rdy,
  input  logic [W-1:0]                 in_msg,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [W-1:0]                 out_msg,
  output logic [$clog2(NPROD+1)-1:0]   cnt
);

  state_e state_q, state_d;
  logic   started_q, started_d;
  logic   in_xfer, out_xfer, last_prod;
  logic [W-1:0] acc;

  lab1_imul_prod_accum_dpath #(
    .NPROD (NPROD),
    .W     (W)
  ) u_dpath (
    .clk       (clk),
    .reset     (reset),
    .in_xfer   (in_xfer),
    .in_msg    (in_msg),
    .acc       (acc),
    .cnt       (cnt),
    .last_prod (last_prod)
  );

  // started_q keeps in_rdy low while reset is held and until the first edge after release
  always_comb begin
    state_d   = state_q;
    started_d = 1'b1;
    in_rdy    = (state_q == ACC) && started_q;
    out_val   = (state_q == DONE);
    out_msg   = acc;
    in_xfer   = in_val && in_rdy;
    out_xfer  = out_val && out_rdy;
    unique case (state_q)
      ACC:  if (in_xfer && last_prod) state_d = DONE;
      DONE: if (out_xfer)             state_d = ACC;
      default:                        state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ACC;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
    end
  end

endmodule
